ppu_regif: RTL and testbench

//  CPU-facing PPU register file ($2000-$2007), successor of the single-fixed-width register interface.

---
 rtl/ppu_regif.sv | 197 +++++++++++++++++++
 tb/tb_ppu_regif.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ppu_regif.sv
`default_nettype none
// ppu_regif: CPU-facing PPU register file ($2000-$2007) with loopy t/v, shared w toggle,
// buffered $2007 reads, OAM auto-increment, vblank status and registered NMI.  Rev 1.0
module ppu_regif #(
  parameter int unsigned        VRAM_AW   = 14,
  parameter int unsigned        OAM_AW    = 8,
  parameter logic [VRAM_AW-1:0] PRAM_BASE = 14'h3F00
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic [2:0]         sel_in,
  input  logic               ncs_in,
  input  logic               r_nw_in,
  input  logic [7:0]         d_in,
  output logic [7:0]         d_out,
  input  logic               vbl_set_in,
  input  logic               vbl_clr_in,
  input  logic               spr_overflow_in,
  input  logic               spr_hit_in,
  output logic [VRAM_AW-1:0] vram_a_out,
  input  logic [7:0]         vram_d_in,
  output logic [7:0]         vram_d_out,
  output logic               vram_wr_out,
  output logic               vram_rd_out,
  input  logic [7:0]         pram_d_in,
  output logic               pram_wr_out,
  output logic [OAM_AW-1:0]  oam_a_out,
  input  logic [7:0]         oam_d_in,
  output logic [7:0]         oam_d_out,
  output logic               oam_wr_out,
  output logic [7:0]         ctrl_out,
  output logic [7:0]         mask_out,
  output logic [14:0]        t_out,
  output logic [2:0]         fh_out,
  output logic               upd_cntrs_out,
  output logic               nmi_out
);

  typedef enum logic [0:0] {
    S_IDLE    = 1'b0,
    S_RD_WAIT = 1'b1
  } state_t;

  state_t               state_q;
  logic                 ncs_q;
  logic                 arm_q;
  logic [7:0]           ctrl_q;
  logic [7:0]           ctrl_d;
  logic [7:0]           mask_q;
  logic [14:0]          t_q;
  logic [2:0]           fh_q;
  logic                 w_q;
  logic [7:0]           buf_q;
  logic [7:0]           rdata_q;
  logic [VRAM_AW-1:0]   v_q;
  logic [OAM_AW-1:0]    oam_a_q;
  logic                 vblank_q;
  logic                 vblank_d;
  logic                 nmi_q;
  logic                 upd_q;

  logic                 acc;
  logic                 rd_acc;
  logic                 wr_acc;
  logic                 in_pram;
  logic [7:0]           rdata;
  logic [VRAM_AW-1:0]   v_inc;

  // arm_q discards an access whose falling ncs edge was hidden by reset.
  // Two accesses are at least two cycles apart, so RD_WAIT (one cycle) always
  // finishes before the next acc arrives and no access is ever dropped.
  assign acc     = ncs_q & ~ncs_in & arm_q;
  assign rd_acc  = acc & r_nw_in;
  assign wr_acc  = acc & ~r_nw_in;
  assign in_pram = (v_q >= PRAM_BASE);
  assign v_inc   = v_q + (ctrl_q[2] ? VRAM_AW'(32) : VRAM_AW'(1));

  always_comb begin
    rdata = buf_q;
    case (sel_in)
      3'd2:    rdata = {vblank_q, spr_hit_in, spr_overflow_in, 5'b00000};
      3'd4:    rdata = oam_d_in;
      3'd7:    rdata = in_pram ? pram_d_in : buf_q;
      default: rdata = buf_q;
    endcase
  end

  always_comb begin
    ctrl_d = (wr_acc && sel_in == 3'd0) ? d_in : ctrl_q;
    vblank_d = vblank_q;
    if (vbl_clr_in)
      vblank_d = 1'b0;
    else if (rd_acc && sel_in == 3'd2)
      vblank_d = 1'b0;
    else if (vbl_set_in)
      vblank_d = 1'b1;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q  <= S_IDLE;
      ncs_q    <= 1'b1;
      arm_q    <= 1'b0;
      ctrl_q   <= '0;
      mask_q   <= '0;
      t_q      <= '0;
      fh_q     <= '0;
      w_q      <= 1'b0;
      buf_q    <= '0;
      rdata_q  <= '0;
      v_q      <= '0;
      oam_a_q  <= '0;
      vblank_q <= 1'b0;
      nmi_q    <= 1'b1;
      upd_q    <= 1'b0;
    end else begin
      ncs_q    <= ncs_in;
      arm_q    <= arm_q | ncs_in;
      upd_q    <= 1'b0;
      ctrl_q   <= ctrl_d;
      vblank_q <= vblank_d;
      nmi_q    <= ~(vblank_d & ctrl_d[7]);

      if (rd_acc)
        rdata_q <= rdata;
      if (upd_q)
        v_q <= t_q[VRAM_AW-1:0];

      case (state_q)
        S_IDLE: begin
          if (rd_acc && sel_in == 3'd7)
            state_q <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          buf_q   <= vram_d_in;
          v_q     <= v_inc;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase

      if (rd_acc && sel_in == 3'd2)
        w_q <= 1'b0;

      if (wr_acc) begin
        case (sel_in)
          3'd0: t_q[11:10] <= d_in[1:0];
          3'd1: mask_q <= d_in;
          3'd3: oam_a_q <= d_in[OAM_AW-1:0];
          3'd4: oam_a_q <= oam_a_q + OAM_AW'(1);
          3'd5: begin
            if (!w_q) begin
              fh_q     <= d_in[2:0];
              t_q[4:0] <= d_in[7:3];
              w_q      <= 1'b1;
            end else begin
              t_q[14:12] <= d_in[2:0];
              t_q[9:5]   <= d_in[7:3];
              w_q        <= 1'b0;
            end
          end
          3'd6: begin
            if (!w_q) begin
              t_q[13:8] <= d_in[5:0];
              t_q[14]   <= 1'b0;
              w_q       <= 1'b1;
            end else begin
              t_q[7:0] <= d_in;
              w_q      <= 1'b0;
              upd_q    <= 1'b1;
            end
          end
          3'd7: v_q <= v_inc;
          default: ;
        endcase
      end
    end
  end

  assign d_out         = (!ncs_in && r_nw_in) ? (rd_acc ? rdata : rdata_q) : 8'h00;
  assign vram_a_out    = v_q;
  assign vram_d_out    = d_in;
  assign vram_wr_out   = wr_acc & (sel_in == 3'd7) & ~in_pram;
  assign pram_wr_out   = wr_acc & (sel_in == 3'd7) & in_pram;
  assign vram_rd_out   = rd_acc & (sel_in == 3'd7);
  assign oam_a_out     = oam_a_q;
  assign oam_d_out     = d_in;
  assign oam_wr_out    = wr_acc & (sel_in == 3'd4);
  assign ctrl_out      = ctrl_q;
  assign mask_out      = mask_q;
  assign t_out         = t_q;
  assign fh_out        = fh_q;
  assign upd_cntrs_out = upd_q;
  assign nmi_out       = nmi_q;

endmodule
`default_nettype wire

// File: tb/tb_ppu_regif.sv
`default_nettype none
// tb_ppu_regif: table-driven register access vectors plus hand-written vblank/NMI/reset sequences.
module tb_ppu_regif;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  sel = 3'd0;
  logic        ncs = 1'b1;
  logic        rnw = 1'b1;
  logic [7:0]  din = 8'h00;
  logic [7:0]  dout;
  logic        vbl_set = 1'b0;
  logic        vbl_clr = 1'b0;
  logic        ovf = 1'b0;
  logic        hit = 1'b1;
  logic [13:0] vaddr;
  logic [7:0]  vram_rdata = 8'h00;
  logic [7:0]  vram_wdata;
  logic        vram_wr;
  logic        vram_rd;
  logic [7:0]  pram_rdata;
  logic        pram_wr;
  logic [7:0]  oam_a;
  logic [7:0]  oam_rdata;
  logic [7:0]  oam_wdata;
  logic        oam_wr;
  logic [7:0]  ctrl;
  logic [7:0]  mask;
  logic [14:0] t;
  logic [2:0]  fh;
  logic        upd;
  logic        nmi;

  logic [7:0]  vmem [0:16383];
  logic [7:0]  pmem [0:31];
  logic [7:0]  omem [0:255];
  int          upd_cnt = 0;

  int n_cmp = 0;
  int n_bad = 0;

  ppu_regif dut (
    .clk_in          (clk),
    .rst_in          (rst),
    .sel_in          (sel),
    .ncs_in          (ncs),
    .r_nw_in         (rnw),
    .d_in            (din),
    .d_out           (dout),
    .vbl_set_in      (vbl_set),
    .vbl_clr_in      (vbl_clr),
    .spr_overflow_in (ovf),
    .spr_hit_in      (hit),
    .vram_a_out      (vaddr),
    .vram_d_in       (vram_rdata),
    .vram_d_out      (vram_wdata),
    .vram_wr_out     (vram_wr),
    .vram_rd_out     (vram_rd),
    .pram_d_in       (pram_rdata),
    .pram_wr_out     (pram_wr),
    .oam_a_out       (oam_a),
    .oam_d_in        (oam_rdata),
    .oam_d_out       (oam_wdata),
    .oam_wr_out      (oam_wr),
    .ctrl_out        (ctrl),
    .mask_out        (mask),
    .t_out           (t),
    .fh_out          (fh),
    .upd_cntrs_out   (upd),
    .nmi_out         (nmi)
  );

  always #5 clk = ~clk;

  assign pram_rdata = pmem[vaddr[4:0]];
  assign oam_rdata  = omem[oam_a];

  // Memories behind the DUT; preset contents are reloaded while reset is held.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16384; i++) vmem[i] <= 8'h00;
      for (int i = 0; i < 32; i++) pmem[i] <= 8'h00;
      for (int i = 0; i < 256; i++) omem[i] <= 8'h00;
      vmem[14'h2108] <= 8'hAA;
      vmem[14'h2109] <= 8'hBB;
      pmem[0] <= 8'h0F;
    end else begin
      if (vram_wr) vmem[vaddr] <= vram_wdata;
      if (pram_wr) pmem[vaddr[4:0]] <= vram_wdata;
      if (oam_wr) omem[oam_a] <= oam_wdata;
      if (vram_rd) vram_rdata <= vmem[vaddr];
    end
  end

  always @(posedge clk) if (upd) upd_cnt <= upd_cnt + 1;

  task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %0h want %0h", nm, idx, act, exp);
    end
  endtask

  task automatic bus(input logic [2:0] s, input logic rw, input logic [7:0] dv,
                     output logic [7:0] q, output logic [3:0] stb);
    @(negedge clk);
    sel = s; rnw = rw; din = dv; ncs = 1'b0;
    #1 stb = {vram_wr, pram_wr, vram_rd, oam_wr};
    @(negedge clk);
    q = dout;
    ncs = 1'b1; rnw = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse(input logic s, input logic c);
    @(negedge clk);
    vbl_set = s; vbl_clr = c;
    @(negedge clk);
    vbl_set = 1'b0; vbl_clr = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  sel;
    logic        rnw;
    logic [7:0]  d;
    logic [7:0]  q;
    logic [3:0]  stb;
    logic [13:0] v;
    logic [14:0] t;
    logic [2:0]  fh;
    logic [7:0]  oam;
    int          upd;
    logic [7:0]  mask;
  } vec_t;

  localparam logic [3:0] VW = 4'b1000, PW = 4'b0100, RD = 4'b0010, OW = 4'b0001, NO = 4'b0000;

  vec_t tbl [35];

  initial begin
    logic [7:0] q;
    logic [3:0] stb;
    int         n_stb;

    //              sel   rnw   d      q      stb v         t          fh    oam    upd mask
    tbl[0]  = '{3'd6, 1'b0, 8'h21, 8'h00, NO, 14'h0000, 15'h2100, 3'd0, 8'h00, 0, 8'h00};
    tbl[1]  = '{3'd6, 1'b0, 8'h08, 8'h00, NO, 14'h2108, 15'h2108, 3'd0, 8'h00, 1, 8'h00};
    tbl[2]  = '{3'd6, 1'b0, 8'h3F, 8'h00, NO, 14'h2108, 15'h3F08, 3'd0, 8'h00, 1, 8'h00};
    tbl[3]  = '{3'd2, 1'b1, 8'h00, 8'h40, NO, 14'h2108, 15'h3F08, 3'd0, 8'h00, 1, 8'h00};
    tbl[4]  = '{3'd6, 1'b0, 8'h21, 8'h00, NO, 14'h2108, 15'h2108, 3'd0, 8'h00, 1, 8'h00};
    tbl[5]  = '{3'd6, 1'b0, 8'h08, 8'h00, NO, 14'h2108, 15'h2108, 3'd0, 8'h00, 2, 8'h00};
    tbl[6]  = '{3'd7, 1'b1, 8'h00, 8'h00, RD, 14'h2109, 15'h2108, 3'd0, 8'h00, 2, 8'h00};
    tbl[7]  = '{3'd7, 1'b1, 8'h00, 8'hAA, RD, 14'h210A, 15'h2108, 3'd0, 8'h00, 2, 8'h00};
    tbl[8]  = '{3'd0, 1'b1, 8'h00, 8'hBB, NO, 14'h210A, 15'h2108, 3'd0, 8'h00, 2, 8'h00};
    tbl[9]  = '{3'd1, 1'b0, 8'h1E, 8'h00, NO, 14'h210A, 15'h2108, 3'd0, 8'h00, 2, 8'h1E};
    tbl[10] = '{3'd6, 1'b0, 8'h3F, 8'h00, NO, 14'h210A, 15'h3F08, 3'd0, 8'h00, 2, 8'h1E};
    tbl[11] = '{3'd6, 1'b0, 8'h00, 8'h00, NO, 14'h3F00, 15'h3F00, 3'd0, 8'h00, 3, 8'h1E};
    tbl[12] = '{3'd7, 1'b1, 8'h00, 8'h0F, RD, 14'h3F01, 15'h3F00, 3'd0, 8'h00, 3, 8'h1E};
    tbl[13] = '{3'd0, 1'b0, 8'h06, 8'h00, NO, 14'h3F01, 15'h3B00, 3'd0, 8'h00, 3, 8'h1E};
    tbl[14] = '{3'd6, 1'b0, 8'h3F, 8'h00, NO, 14'h3F01, 15'h3F00, 3'd0, 8'h00, 3, 8'h1E};
    tbl[15] = '{3'd6, 1'b0, 8'hF0, 8'h00, NO, 14'h3FF0, 15'h3FF0, 3'd0, 8'h00, 4, 8'h1E};
    tbl[16] = '{3'd7, 1'b0, 8'h55, 8'h00, PW, 14'h0010, 15'h3FF0, 3'd0, 8'h00, 4, 8'h1E};
    tbl[17] = '{3'd7, 1'b0, 8'h66, 8'h00, VW, 14'h0030, 15'h3FF0, 3'd0, 8'h00, 4, 8'h1E};
    tbl[18] = '{3'd3, 1'b0, 8'hFF, 8'h00, NO, 14'h0030, 15'h3FF0, 3'd0, 8'hFF, 4, 8'h1E};
    tbl[19] = '{3'd4, 1'b0, 8'h11, 8'h00, OW, 14'h0030, 15'h3FF0, 3'd0, 8'h00, 4, 8'h1E};
    tbl[20] = '{3'd4, 1'b0, 8'h22, 8'h00, OW, 14'h0030, 15'h3FF0, 3'd0, 8'h01, 4, 8'h1E};
    tbl[21] = '{3'd3, 1'b0, 8'hFF, 8'h00, NO, 14'h0030, 15'h3FF0, 3'd0, 8'hFF, 4, 8'h1E};
    tbl[22] = '{3'd4, 1'b1, 8'h00, 8'h11, NO, 14'h0030, 15'h3FF0, 3'd0, 8'hFF, 4, 8'h1E};
    tbl[23] = '{3'd3, 1'b0, 8'h00, 8'h00, NO, 14'h0030, 15'h3FF0, 3'd0, 8'h00, 4, 8'h1E};
    tbl[24] = '{3'd4, 1'b1, 8'h00, 8'h22, NO, 14'h0030, 15'h3FF0, 3'd0, 8'h00, 4, 8'h1E};
    tbl[25] = '{3'd6, 1'b0, 8'h00, 8'h00, NO, 14'h0030, 15'h00F0, 3'd0, 8'h00, 4, 8'h1E};
    tbl[26] = '{3'd6, 1'b0, 8'h10, 8'h00, NO, 14'h0010, 15'h0010, 3'd0, 8'h00, 5, 8'h1E};
    tbl[27] = '{3'd7, 1'b1, 8'h00, 8'h00, RD, 14'h0030, 15'h0010, 3'd0, 8'h00, 5, 8'h1E};
    tbl[28] = '{3'd7, 1'b1, 8'h00, 8'h66, RD, 14'h0050, 15'h0010, 3'd0, 8'h00, 5, 8'h1E};
    tbl[29] = '{3'd6, 1'b0, 8'h3F, 8'h00, NO, 14'h0050, 15'h3F10, 3'd0, 8'h00, 5, 8'h1E};
    tbl[30] = '{3'd6, 1'b0, 8'hF0, 8'h00, NO, 14'h3FF0, 15'h3FF0, 3'd0, 8'h00, 6, 8'h1E};
    tbl[31] = '{3'd7, 1'b1, 8'h00, 8'h55, RD, 14'h0010, 15'h3FF0, 3'd0, 8'h00, 6, 8'h1E};
    tbl[32] = '{3'd5, 1'b0, 8'h7D, 8'h00, NO, 14'h0010, 15'h3FEF, 3'd5, 8'h00, 6, 8'h1E};
    tbl[33] = '{3'd5, 1'b0, 8'h5E, 8'h00, NO, 14'h0010, 15'h6D6F, 3'd5, 8'h00, 6, 8'h1E};
    tbl[34] = '{3'd2, 1'b1, 8'h00, 8'h40, NO, 14'h0010, 15'h6D6F, 3'd5, 8'h00, 6, 8'h1E};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_nmi", 0, 32'(nmi), 32'd1);
    check("rst_vaddr", 0, 32'(vaddr), 32'd0);
    check("rst_dout", 0, 32'(dout), 32'd0);
    check("rst_t", 0, 32'(t), 32'd0);
    check("rst_ctrl", 0, 32'(ctrl), 32'd0);
    check("rst_stb", 0, 32'({vram_wr, pram_wr, vram_rd, oam_wr, upd}), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 35; i++) begin
      bus(tbl[i].sel, tbl[i].rnw, tbl[i].d, q, stb);
      if (tbl[i].rnw) check("dout", i, 32'(q), 32'(tbl[i].q));
      check("strobes", i, 32'(stb), 32'(tbl[i].stb));
      check("vaddr", i, 32'(vaddr), 32'(tbl[i].v));
      check("t", i, 32'(t), 32'(tbl[i].t));
      check("fh", i, 32'(fh), 32'(tbl[i].fh));
      check("oam_a", i, 32'(oam_a), 32'(tbl[i].oam));
      check("upd_cnt", i, 32'(upd_cnt), 32'(tbl[i].upd));
      check("mask", i, 32'(mask), 32'(tbl[i].mask));
    end

    // vblank, NMI enable and $2002 side effects
    hit = 1'b0;
    bus(3'd0, 1'b0, 8'h00, q, stb);
    check("nmi_idle", 0, 32'(nmi), 32'd1);
    pulse(1'b1, 1'b0);
    check("nmi_vbl_disabled", 0, 32'(nmi), 32'd1);
    @(negedge clk);
    sel = 3'd0; rnw = 1'b0; din = 8'h80; ncs = 1'b0;
    @(negedge clk);
    check("nmi_ctrl_enable", 0, 32'(nmi), 32'd0);
    ncs = 1'b1; rnw = 1'b1;
    @(negedge clk);
    bus(3'd5, 1'b0, 8'h03, q, stb);
    check("fh_w0", 0, 32'(fh), 32'd3);
    bus(3'd2, 1'b1, 8'h00, q, stb);
    check("status_vbl", 0, 32'(q), 32'h80);
    check("nmi_after_status", 0, 32'(nmi), 32'd1);
    bus(3'd2, 1'b1, 8'h00, q, stb);
    check("status_cleared", 0, 32'(q), 32'h00);
    bus(3'd5, 1'b0, 8'h0A, q, stb);
    check("fh_w_cleared", 0, 32'(fh), 32'd2);
    pulse(1'b1, 1'b0);
    check("nmi_set", 0, 32'(nmi), 32'd0);
    pulse(1'b0, 1'b1);
    check("nmi_clr", 0, 32'(nmi), 32'd1);
    bus(3'd2, 1'b1, 8'h00, q, stb);
    check("status_after_clr", 0, 32'(q), 32'h00);
    pulse(1'b1, 1'b1);
    check("nmi_clr_wins", 0, 32'(nmi), 32'd1);
    bus(3'd2, 1'b1, 8'h00, q, stb);
    check("status_clr_wins", 0, 32'(q), 32'h00);

    // $2002 read on the vbl_set cycle suppresses the flag
    @(negedge clk);
    sel = 3'd2; rnw = 1'b1; ncs = 1'b0; vbl_set = 1'b1;
    @(negedge clk);
    vbl_set = 1'b0;
    q = dout;
    ncs = 1'b1;
    check("race_dout", 0, 32'(q), 32'h00);
    check("race_nmi", 0, 32'(nmi), 32'd1);
    @(negedge clk);
    bus(3'd2, 1'b1, 8'h00, q, stb);
    check("race_vbl_stays0", 0, 32'(q), 32'h00);

    // Reset asserted in the middle of a $2007 read, released with ncs still low
    bus(3'd5, 1'b0, 8'h00, q, stb);
    check("w_set_before_rst", 0, 32'(fh), 32'd0);
    @(negedge clk);
    sel = 3'd7; rnw = 1'b1; ncs = 1'b0;
    #1 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_nmi", 0, 32'(nmi), 32'd1);
    check("mid_rst_vaddr", 0, 32'(vaddr), 32'd0);
    check("mid_rst_t", 0, 32'(t), 32'd0);
    n_stb = 0;
    for (int k = 0; k < 4; k++) begin
      #1 n_stb += int'(vram_rd) + int'(vram_wr) + int'(pram_wr) + int'(oam_wr) + int'(upd);
      @(negedge clk);
    end
    check("mid_rst_no_strobe", 0, 32'(n_stb), 32'd0);
    check("mid_rst_vaddr_hold", 0, 32'(vaddr), 32'd0);
    ncs = 1'b1;
    @(negedge clk);
    bus(3'd5, 1'b0, 8'h0B, q, stb);
    check("mid_rst_w0", 0, 32'(fh), 32'd3);
    check("mid_rst_t_lo", 0, 32'(t), 32'h0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
